wb_stage_regfile: RTL and testbench
===================================

WB_STAGE_REGFILE -- requirements
Module: wb_stage_regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath width; only 32 is supported.
REQ-002 The block SHALL have parameter RF_DEPTH, default 32, meaning the number of architectural registers (x0..x31).
REQ-003 clk_MemWB  in  1  clock; all state updates on rising edge.
REQ-004 rst_MemWB  in  1  reset, asynchronous, active-high.
REQ-005 en_WB  in  1  writeback enable; 0 = pipeline stalled.
REQ-006 valid_in_WB  in  1  instruction in WB is valid (not a bubble).
REQ-007 PC_in_WB  in  32  PC of the instruction in WB (trace only).
REQ-008 PC4_in_WB  in  32  PC+4 of the instruction in WB.
REQ-009 Inst_in_WB  in  32  instruction word; funct3 = Inst_in_WB[14:12].
REQ-010 Rd_addr_in_WB  in  5  destination register.
REQ-011 ALU_in_WB  in  32  ALU result; [1:0] is the load byte offset.
REQ-012 DMem_data_in_WB  in  32  raw aligned data-memory word.
REQ-013 MemtoReg_in_WB  in  2  result select.
REQ-014 RegWrite_in_WB  in  1  register write request.
REQ-015 rs1_addr, rs2_addr  in  5 each  ID-stage read addresses.
REQ-016 rs1_data, rs2_data  out  32 each  read data.
REQ-017 wb_fwd_valid / wb_fwd_rd / wb_fwd_data  out  1/5/32  forwarding bus to the hazard unit.
REQ-018 instret  out  64  retired-instruction count; cycle  out  64  cycle count.
REQ-019 dbg_addr  in  5; dbg_data  out  32  debug read port (no bypass).

Function
REQ-020 Load extraction SHALL use funct3 and off = ALU_in_WB[1:0]: 000 LB sign-extend byte[off]; 001 LH sign-extend half[off[1]]; 010 LW full word; 100 LBU zero-extend byte[off]; 101 LHU zero-extend half[off[1]]; other values pass the raw word.
REQ-021 For LH/LHU, off[0] SHALL be ignored; for LW, off SHALL be ignored.
REQ-022 wb_data SHALL be: MemtoReg 00 ALU_in_WB; 01 extracted load data; 10 PC4_in_WB; 11 32'h0.
REQ-023 The write strobe we SHALL be valid_in_WB & en_WB & RegWrite_in_WB & (Rd_addr_in_WB != 0).
REQ-024 When we=1, register[Rd_addr_in_WB] SHALL take wb_data on the rising edge; otherwise the register file SHALL hold.
REQ-025 x0 SHALL always read 0 and SHALL never be written.
REQ-026 Read ports SHALL be combinational; if we=1 and rsN_addr==Rd_addr_in_WB (nonzero), rsN_data SHALL be wb_data in the same cycle (write-through bypass).
REQ-027 wb_fwd_valid SHALL equal we; wb_fwd_rd SHALL be Rd_addr_in_WB; wb_fwd_data SHALL be wb_data; all combinational.
REQ-028 instret SHALL increment by 1 on each edge with valid_in_WB & en_WB, and SHALL wrap from 2^64-1 to 0.
REQ-029 cycle SHALL increment by 1 on every edge not in reset, independent of en_WB, and SHALL wrap.
REQ-030 A stalled instruction (en_WB=0) SHALL produce no write and no instret increment; it is counted once, when en_WB rises.
REQ-031 dbg_data SHALL be the stored register[dbg_addr] (0 for x0), with no bypass.

Reset
REQ-032 On rst_MemWB=1, all registers x1..x31, instret, and cycle SHALL clear to 0 immediately, regardless of clock.
REQ-033 While in reset, writes SHALL be suppressed, and reads SHALL return 0 unless bypassed.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight write with no partial update.

Verification
REQ-035 Reset, then LB, DMem=32'h8000_7F00, ALU[1:0]=01, rd=5, MemtoReg=01, valid/en/RegWrite=1 -> x5=32'h0000_007F; repeat with off=11 -> x5=32'hFFFF_FF80.
REQ-036 LHU, DMem=32'hBEEF_1234, off=10, rd=7 -> x7=32'h0000_BEEF; LH with the same inputs -> x7=32'hFFFF_BEEF.
REQ-037 JAL writeback, MemtoReg=10, PC4=32'h0000_0104, rd=1, and rs1_addr=1 in the same cycle -> rs1_data=32'h104 combinationally; x1=32'h104 after the edge.
REQ-038 RegWrite=1 with rd=0 and ALU=32'hDEAD -> wb_fwd_valid=0 and x0 reads 0; valid=0 bubble -> no write and instret unchanged.
REQ-039 en_WB=0 for 3 cycles, then 1, with a valid instruction -> cycle +4, instret +1, a single write.
REQ-040 Preload instret to 2^64-1 through a forced sequence, then retire one instruction -> instret=0; assert rst_MemWB between edges -> all outputs and counters 0 without waiting for a clock edge.

Source files
------------

// File: rtl/wb_stage_regfile.sv
// Writeback stage with an integrated 32-entry register file.
// The stage extracts load data, selects the writeback value and writes it to
// the register file. It also drives the forwarding bus and keeps the retired
// instruction and cycle counters. Reads see the write in the same cycle, and
// a separate debug port shows the stored state with no bypass.
module wb_stage_regfile #(
  parameter int XLEN     = 32,
  parameter int RF_DEPTH = 32
) (
  input  logic            clk_MemWB,
  input  logic            rst_MemWB,
  input  logic            en_WB,
  input  logic            valid_in_WB,
  input  logic [XLEN-1:0] PC_in_WB,
  input  logic [XLEN-1:0] PC4_in_WB,
  input  logic [XLEN-1:0] Inst_in_WB,
  input  logic [4:0]      Rd_addr_in_WB,
  input  logic [XLEN-1:0] ALU_in_WB,
  input  logic [XLEN-1:0] DMem_data_in_WB,
  input  logic [1:0]      MemtoReg_in_WB,
  input  logic            RegWrite_in_WB,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_fwd_valid,
  output logic [4:0]      wb_fwd_rd,
  output logic [XLEN-1:0] wb_fwd_data,
  output logic [63:0]     instret,
  output logic [63:0]     cycle,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback result select encodings.
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic [XLEN-1:0] regs_q [RF_DEPTH];

  logic [2:0]      funct3;
  logic [1:0]      byte_off;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;
  logic            we;
  logic            retire;

  logic [63:0]     instret_q;
  logic [63:0]     instret_d;
  logic [63:0]     cycle_q;
  logic [63:0]     cycle_d;

  // The PC and the non-funct3 instruction bits are carried for tracing only.
  logic unused_trace;
  assign unused_trace = ^{PC_in_WB, Inst_in_WB[31:15], Inst_in_WB[11:0]};

  assign funct3   = Inst_in_WB[14:12];
  assign byte_off = ALU_in_WB[1:0];

  // Pick the addressed byte and half-word out of the aligned memory word.
  always_comb begin
    load_byte = DMem_data_in_WB[7:0];
    case (byte_off)
      2'b00:   load_byte = DMem_data_in_WB[7:0];
      2'b01:   load_byte = DMem_data_in_WB[15:8];
      2'b10:   load_byte = DMem_data_in_WB[23:16];
      default: load_byte = DMem_data_in_WB[31:24];
    endcase
    // Half-word loads are treated as aligned, so off[0] is ignored.
    load_half = byte_off[1] ? DMem_data_in_WB[31:16] : DMem_data_in_WB[15:0];
  end

  // Extend the selected piece according to the load type.
  always_comb begin
    load_data = DMem_data_in_WB;
    case (funct3)
      F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{16{load_half[15]}}, load_half};
      F3_LW:   load_data = DMem_data_in_WB;
      F3_LBU:  load_data = {24'd0, load_byte};
      F3_LHU:  load_data = {16'd0, load_half};
      default: load_data = DMem_data_in_WB;
    endcase
  end

  // Select the value written back.
  always_comb begin
    wb_data = '0;
    case (MemtoReg_in_WB)
      SEL_ALU:  wb_data = ALU_in_WB;
      SEL_LOAD: wb_data = load_data;
      SEL_PC4:  wb_data = PC4_in_WB;
      default:  wb_data = '0;
    endcase
  end

  // A write needs a live, unstalled instruction that targets a register other than x0.
  assign we     = valid_in_WB & en_WB & RegWrite_in_WB & (Rd_addr_in_WB != 5'd0);
  assign retire = valid_in_WB & en_WB;

  assign wb_fwd_valid = we;
  assign wb_fwd_rd    = Rd_addr_in_WB;
  assign wb_fwd_data  = wb_data;

  // Register file storage. Reset clears every entry at once. Entry 0 is never
  // written, so it stays zero.
  always_ff @(posedge clk_MemWB or posedge rst_MemWB) begin
    if (rst_MemWB) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[Rd_addr_in_WB] <= wb_data;
    end
  end

  // Read port 1: the current writeback value takes priority over stored data.
  always_comb begin
    rs1_data = '0;
    if (we && (rs1_addr == Rd_addr_in_WB)) begin
      rs1_data = wb_data;
    end else if (rs1_addr != 5'd0) begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  // Read port 2: same bypass rule as port 1.
  always_comb begin
    rs2_data = '0;
    if (we && (rs2_addr == Rd_addr_in_WB)) begin
      rs2_data = wb_data;
    end else if (rs2_addr != 5'd0) begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  // Debug port: stored contents only, never the in-flight write.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != 5'd0) begin
      dbg_data = regs_q[dbg_addr];
    end
  end

  // Counter next-state values. Both counters wrap naturally at 2^64.
  assign instret_d = instret_q + {63'd0, retire};
  assign cycle_d   = cycle_q + 64'd1;

  // Retired-instruction and free-running cycle counters.
  always_ff @(posedge clk_MemWB or posedge rst_MemWB) begin
    if (rst_MemWB) begin
      instret_q <= '0;
      cycle_q   <= '0;
    end else begin
      instret_q <= instret_d;
      cycle_q   <= cycle_d;
    end
  end

  assign instret = instret_q;
  assign cycle   = cycle_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Testbench for wb_stage_regfile. Directed cases are followed by random
// traffic. Every result is compared against an array/counter reference model.
module tb_wb_stage_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, valid, regw;
  logic [31:0] pc, pc4, inst, alu, dmem;
  logic [4:0]  rd, rs1a, rs2a, dbga;
  logic [1:0]  mtr;
  logic [31:0] rs1_data, rs2_data, fwd_data, dbg_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] instret, cycle;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [63:0] m_instret, m_cycle;

  always #5 clk = ~clk;

  wb_stage_regfile #(.XLEN(32), .RF_DEPTH(32)) dut (
    .clk_MemWB(clk), .rst_MemWB(rst), .en_WB(en), .valid_in_WB(valid),
    .PC_in_WB(pc), .PC4_in_WB(pc4), .Inst_in_WB(inst), .Rd_addr_in_WB(rd),
    .ALU_in_WB(alu), .DMem_data_in_WB(dmem), .MemtoReg_in_WB(mtr),
    .RegWrite_in_WB(regw), .rs1_addr(rs1a), .rs2_addr(rs2a),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_fwd_valid(fwd_valid),
    .wb_fwd_rd(fwd_rd), .wb_fwd_data(fwd_data), .instret(instret),
    .cycle(cycle), .dbg_addr(dbga), .dbg_data(dbg_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load value computed with shifts and masks from the load rules.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] b8, h16;
    b8  = (w >> (8 * off)) & 32'hFF;
    h16 = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b8 >= 32'd128) ? b8 - 32'd256 : b8;
      3'd1:    return (h16 >= 32'd32768) ? h16 - 32'd65536 : h16;
      3'd4:    return b8;
      3'd5:    return h16;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_wb();
    logic [2:0] f3;
    f3 = inst[14:12];
    case (mtr)
      2'd0:    return alu;
      2'd1:    return m_load(f3, alu[1:0], dmem);
      2'd2:    return pc4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_we();
    return valid && en && regw && (rd != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_regs[a];
  endfunction

  function automatic logic [31:0] m_rs(input logic [4:0] a);
    if (m_we() && a == rd) return m_wb();
    return m_read(a);
  endfunction

  task automatic set_tx(input logic v, input logic e, input logic w, input logic [2:0] f3,
                        input logic [4:0] d, input logic [31:0] a, input logic [31:0] dm,
                        input logic [1:0] ms, input logic [31:0] p4);
    valid = v; en = e; regw = w;
    inst = 32'h0000_0003; inst[14:12] = f3;
    rd = d; alu = a; dmem = dm; mtr = ms; pc4 = p4; pc = p4 - 32'd4;
  endtask

  // Combinational outputs for the inputs currently applied.
  task automatic comb_check();
    #1;
    chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, m_we()});
    chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, rd});
    chk("fwd_data", {32'd0, fwd_data}, {32'd0, m_wb()});
    chk("rs1_data", {32'd0, rs1_data}, {32'd0, m_rs(rs1a)});
    chk("rs2_data", {32'd0, rs2_data}, {32'd0, m_rs(rs2a)});
  endtask

  // Clock once, update the model, then check the state and the counters.
  task automatic clock_check();
    @(posedge clk);
    if (m_we()) m_regs[rd] = m_wb();
    if (valid && en) m_instret = m_instret + 64'd1;
    m_cycle = m_cycle + 64'd1;
    @(negedge clk);
    #1;
    chk("instret", instret, m_instret);
    chk("cycle", cycle, m_cycle);
    chk("dbg_data", {32'd0, dbg_data}, {32'd0, m_read(dbga)});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_instret = 64'd0;
    m_cycle = 64'd0;
  endtask

  initial begin
    logic [63:0] i0, c0;
    rst = 1'b1;
    set_tx(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 2'd0, 32'd4);
    rs1a = 5'd0; rs2a = 5'd0; dbga = 5'd0;
    model_reset();

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst_instret", instret, 64'd0);
    chk("rst_cycle", cycle, 64'd0);
    chk("rst_dbg", {32'd0, dbg_data}, 64'd0);
    rs1a = 5'd3; rs2a = 5'd17; dbga = 5'd9;
    #1;
    chk("rst_rs1", {32'd0, rs1_data}, 64'd0);
    chk("rst_rs2", {32'd0, rs2_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // LB at offset 1, then at offset 3.
    set_tx(1'b1, 1'b1, 1'b1, 3'b000, 5'd5, 32'h0000_0001, 32'h8000_7F00, 2'b01, 32'd8);
    dbga = 5'd5;
    comb_check();
    clock_check();
    chk("lb_off1", {32'd0, dbg_data}, {32'd0, 32'h0000_007F});
    set_tx(1'b1, 1'b1, 1'b1, 3'b000, 5'd5, 32'h0000_0003, 32'h8000_7F00, 2'b01, 32'd12);
    comb_check();
    clock_check();
    chk("lb_off3", {32'd0, dbg_data}, {32'd0, 32'hFFFF_FF80});

    // LHU and LH on the upper half-word.
    set_tx(1'b1, 1'b1, 1'b1, 3'b101, 5'd7, 32'h0000_0002, 32'hBEEF_1234, 2'b01, 32'd16);
    dbga = 5'd7;
    comb_check();
    clock_check();
    chk("lhu_off2", {32'd0, dbg_data}, {32'd0, 32'h0000_BEEF});
    set_tx(1'b1, 1'b1, 1'b1, 3'b001, 5'd7, 32'h0000_0002, 32'hBEEF_1234, 2'b01, 32'd20);
    comb_check();
    clock_check();
    chk("lh_off2", {32'd0, dbg_data}, {32'd0, 32'hFFFF_BEEF});

    // JAL link write, bypassed to rs1 in the same cycle.
    set_tx(1'b1, 1'b1, 1'b1, 3'b000, 5'd1, 32'h0000_0040, 32'h0, 2'b10, 32'h0000_0104);
    rs1a = 5'd1; dbga = 5'd1;
    comb_check();
    chk("jal_bypass", {32'd0, rs1_data}, {32'd0, 32'h0000_0104});
    chk("jal_dbg_nobypass", {32'd0, dbg_data}, 64'd0);
    clock_check();
    chk("jal_x1", {32'd0, dbg_data}, {32'd0, 32'h0000_0104});

    // Write to x0 is dropped.
    set_tx(1'b1, 1'b1, 1'b1, 3'b010, 5'd0, 32'h0000_DEAD, 32'h0, 2'b00, 32'd24);
    rs1a = 5'd0; dbga = 5'd0;
    comb_check();
    chk("x0_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("x0_rs1", {32'd0, rs1_data}, 64'd0);
    clock_check();
    chk("x0_dbg", {32'd0, dbg_data}, 64'd0);

    // Bubble: no write and no retire.
    i0 = instret;
    set_tx(1'b0, 1'b1, 1'b1, 3'b010, 5'd3, 32'h1234_5678, 32'h0, 2'b00, 32'd28);
    dbga = 5'd3;
    comb_check();
    clock_check();
    chk("bubble_instret", instret, i0);
    chk("bubble_x3", {32'd0, dbg_data}, 64'd0);

    // Stall for three cycles, then release.
    i0 = instret; c0 = cycle;
    set_tx(1'b1, 1'b0, 1'b1, 3'b010, 5'd12, 32'hCAFE_F00D, 32'h0, 2'b00, 32'd32);
    dbga = 5'd12; rs2a = 5'd12;
    for (int k = 0; k < 3; k++) begin
      comb_check();
      clock_check();
    end
    chk("stall_nowrite", {32'd0, dbg_data}, 64'd0);
    en = 1'b1;
    comb_check();
    clock_check();
    chk("stall_cycle", cycle - c0, 64'd4);
    chk("stall_instret", instret - i0, 64'd1);
    chk("stall_x12", {32'd0, dbg_data}, {32'd0, 32'hCAFE_F00D});

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      set_tx($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
             3'($urandom), 5'($urandom), $urandom, $urandom, 2'($urandom), $urandom);
      inst[31:15] = 17'($urandom);
      rs1a = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      rs2a = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      dbga = 5'($urandom);
      comb_check();
      clock_check();
    end

    // Drive instret to all ones, then retire one instruction so it wraps.
    set_tx(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 2'd0, 32'd4);
    force dut.instret_d = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    m_cycle = m_cycle + 64'd1;
    @(negedge clk);
    release dut.instret_d;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("preload_instret", instret, m_instret);
    set_tx(1'b1, 1'b1, 1'b1, 3'b010, 5'd20, 32'h0BAD_BEEF, 32'h0, 2'b00, 32'd8);
    dbga = 5'd20;
    comb_check();
    clock_check();
    chk("instret_wrap", instret, 64'd0);

    // Reset between edges clears the state at once and drops the pending write.
    set_tx(1'b1, 1'b1, 1'b1, 3'b010, 5'd9, 32'h5555_AAAA, 32'h0, 2'b00, 32'd8);
    rs1a = 5'd9; rs2a = 5'd20; dbga = 5'd20;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_instret", instret, 64'd0);
    chk("arst_cycle", cycle, 64'd0);
    chk("arst_dbg", {32'd0, dbg_data}, 64'd0);
    chk("arst_rs2", {32'd0, rs2_data}, 64'd0);
    chk("arst_rs1_bypass", {32'd0, rs1_data}, {32'd0, 32'h5555_AAAA});
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b0;
    dbga = 5'd9;
    #1;
    chk("arst_dropped_write", {32'd0, dbg_data}, 64'd0);
    chk("arst_cycle_held", cycle, 64'd0);
    comb_check();
    clock_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
